quadrature_upconverter: RTL and testbench
=========================================

// Module: quadrature_upconverter
// PURPOSE
//   Transmit-side counterpart of the receive complex mixer. Takes signed baseband I/Q samples,
//   generates its own quadrature LO (phase accumulator + sine/cosine table) and produces the
//   real passband sample rf = I*cos - Q*sin. Sits between baseband sample source and DAC.
//   Carrier frequency is loaded through a valid/ready port and switched phase-continuously.
// PARAMETERS
//   IN_W     5   width of signed baseband I/Q samples
//   LO_W     5   width of signed LO table values; magnitude limited to 2^(LO_W-1)-1
//   PHASE_W  16  phase accumulator / frequency control word width
//   IDX_W    8   phase index bits (top IDX_W bits of accumulator) addressing the LO table
// PORTS
//   clock        in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   clk_en       in   1        sample-rate enable; all state advances only when high (reset excepted)
//   bb_i         in   IN_W     signed baseband in-phase sample
//   bb_q         in   IN_W     signed baseband quadrature sample
//   phase_clear  in   1        on an enabled cycle, force accumulator to 0
//   fcw_in       in   PHASE_W  new frequency control word
//   fcw_valid    in   1        fcw_in valid
//   fcw_ready    out  1        block can accept a new word
//   rf_out       out  IN_W+LO_W  signed passband sample, full precision
//   out_valid    out  1        rf_out carries a real (non-fill) sample
// BEHAVIOUR
//   Reset (priority over clk_en): acc=0, fcw_active=0, pending cleared, fcw_ready=1,
//     all pipeline regs 0, rf_out=0, out_valid=0. Reset mid-operation discards any pending word.
//   LO table: p = acc[PHASE_W-1 -: IDX_W]; cos = round(A*cos(2*pi*p/2^IDX_W)),
//     sin = round(A*sin(2*pi*p/2^IDX_W)), A = 2^(LO_W-1)-1 (15 default), round half away from 0.
//     Quarter-wave or full table allowed; output must match formula bit-exactly.
//   Accumulator, enabled cycle t: sample bb(t) pairs with phase P(t) = acc value before update;
//     acc <= acc + fcw_active mod 2^PHASE_W. If phase_clear: P(t)=0, acc <= fcw_active (next).
//   Pipeline (advances on clk_en only; clk_en low holds every register incl. outputs):
//     S1 register bb_i, bb_q, p | S2 lookup cos/sin, delay bb | S3 pi=bb_i*cos, pq=bb_q*sin
//     (signed, IN_W+LO_W bits) | S4 rf_out <= pi - pq. Latency: 4 enabled edges, sample to rf_out.
//   Width: |pi-pq| <= 2*2^(IN_W-1)*A < 2^(IN_W+LO_W-1); no saturation, no truncation.
//   out_valid: 0 after reset; goes 1 on 4th enabled edge after reset release, stays 1.
//   FCW handshake: transfer when fcw_valid && fcw_ready (any cycle, clk_en not required).
//     On transfer: pending <= fcw_in, fcw_ready <= 0.
//     Apply on first enabled cycle where acc + fcw_active carries out of PHASE_W bits (wrap):
//     that update uses old word, fcw_active <= pending, fcw_ready <= 1 next cycle.
//     If fcw_active == 0 or phase_clear asserted, apply on next enabled cycle instead (no deadlock).
//     fcw_valid while fcw_ready=0 is ignored; source must hold until ready.
//   Simultaneous phase_clear + apply: acc <= old fcw_active, fcw_active <= pending.
// TESTING
//   1 fcw=0, bb_i=3, bb_q=7 constant -> rf_out=45 (cos 15, sin 0) from 4th enabled edge; out_valid 1.
//   2 fcw=0x4000, bb_i=1, bb_q=0 -> rf_out cycles 15,0,-15,0 repeating; bb_i=0,bb_q=1 -> 0,-15,0,15.
//   3 Extremes bb_i=-16, bb_q=15, fcw=0x4000 -> rf_out seq -240,-225,240,225; no overflow.
//   4 Active 0x4000, load 0x2000 at acc=0x4000 -> ready low, applied at wrap (acc 0xC000->0x0000),
//     next phases 0x2000,0x4000...; ready high the following cycle; phase continuous.
//   5 clk_en toggled 1-0-0-1 pseudo-randomly -> output sequence identical to clk_en=1 run, held values
//     unchanged while low; fcw_active=0 and new word -> applied on next enabled cycle.
//   6 Reset asserted with word pending and pipeline full -> all outputs 0, fcw_ready=1, acc=0,
//     pending discarded (fcw_active stays 0 after release).

Source files
------------

// File: rtl/quadrature_upconverter.sv
// Quadrature upconverter: rf = I*cos - Q*sin with an internal phase-accumulator LO.
// Carrier words are accepted over a valid/ready port and take effect at an accumulator wrap.
module quadrature_upconverter #(
    parameter int IN_W    = 5,
    parameter int LO_W    = 5,
    parameter int PHASE_W = 16,
    parameter int IDX_W   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic signed [IN_W-1:0]        bb_i,
    input  logic signed [IN_W-1:0]        bb_q,
    input  logic                          phase_clear,
    input  logic        [PHASE_W-1:0]     fcw_in,
    input  logic                          fcw_valid,
    output logic                          fcw_ready,
    output logic signed [IN_W+LO_W-1:0]   rf_out,
    output logic                          out_valid
);

    localparam int OUT_W = IN_W + LO_W;
    localparam int QTR   = 2 ** (IDX_W - 2);

    // First quarter-wave index at which round(15*sin(2*pi*k/256)) reaches 1..15.
    localparam int SIN_THR [15] = '{2, 5, 7, 10, 13, 16, 19, 22, 25, 28, 32, 36, 41, 46, 54};

    function automatic logic [LO_W-1:0] quarter_sine(input logic [IDX_W-2:0] k);
        logic [LO_W-1:0] m;
        m = '0;
        for (int n = 0; n < 15; n++) begin
            if (int'(k) >= SIN_THR[n]) m = m + LO_W'(1);
        end
        return m;
    endfunction

    function automatic logic signed [LO_W-1:0] lo_sine(input logic [IDX_W-1:0] p);
        logic [1:0]       quad;
        logic [IDX_W-2:0] r;
        logic [LO_W-1:0]  mag;
        quad = p[IDX_W-1 -: 2];
        r    = {1'b0, p[IDX_W-3:0]};
        if (quad[0]) r = (IDX_W-1)'(QTR) - r;
        mag  = quarter_sine(r);
        return quad[1] ? -$signed(mag) : $signed(mag);
    endfunction

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] fcw_active_q, fcw_active_d;
    logic [PHASE_W-1:0] pending_q, pending_d;
    logic               fcw_ready_q, fcw_ready_d;
    logic [PHASE_W:0]   acc_sum;
    logic [IDX_W-1:0]   idx_now;
    logic               apply;

    logic signed [IN_W-1:0] bb_i_p1_q, bb_i_p1_d, bb_q_p1_q, bb_q_p1_d;
    logic [IDX_W-1:0]       idx_p1_q, idx_p1_d;
    logic                   vld_p1_q, vld_p1_d;
    logic signed [LO_W-1:0] cos_p2_q, cos_p2_d, sin_p2_q, sin_p2_d;
    logic signed [IN_W-1:0] bb_i_p2_q, bb_i_p2_d, bb_q_p2_q, bb_q_p2_d;
    logic                   vld_p2_q, vld_p2_d;
    logic signed [OUT_W-1:0] pi_p3_q, pi_p3_d, pq_p3_q, pq_p3_d;
    logic                   vld_p3_q, vld_p3_d;
    logic signed [OUT_W-1:0] rf_p4_q, rf_p4_d;
    logic                   vld_p4_q, vld_p4_d;

    always_comb begin
        acc_d        = acc_q;
        fcw_active_d = fcw_active_q;
        pending_d    = pending_q;
        fcw_ready_d  = fcw_ready_q;
        acc_sum      = {1'b0, acc_q} + {1'b0, fcw_active_q};
        idx_now      = phase_clear ? '0 : acc_q[PHASE_W-1 -: IDX_W];
        // A zero word never wraps and a clear breaks the phase anyway, so both apply at once.
        apply        = clk_en && !fcw_ready_q &&
                       (acc_sum[PHASE_W] || (fcw_active_q == '0) || phase_clear);
        if (clk_en) acc_d = phase_clear ? fcw_active_q : acc_sum[PHASE_W-1:0];
        if (apply) begin
            fcw_active_d = pending_q;
            fcw_ready_d  = 1'b1;
        end else if (fcw_valid && fcw_ready_q) begin
            pending_d    = fcw_in;
            fcw_ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            fcw_active_q <= '0;
            pending_q    <= '0;
            fcw_ready_q  <= 1'b1;
        end else begin
            acc_q        <= acc_d;
            fcw_active_q <= fcw_active_d;
            pending_q    <= pending_d;
            fcw_ready_q  <= fcw_ready_d;
        end
    end

    always_comb begin
        // S1: capture sample with its phase index
        bb_i_p1_d = bb_i;
        bb_q_p1_d = bb_q;
        idx_p1_d  = idx_now;
        vld_p1_d  = 1'b1;
        // S2: LO lookup, cos taken as sine a quarter turn ahead
        cos_p2_d  = lo_sine(idx_p1_q + IDX_W'(QTR));
        sin_p2_d  = lo_sine(idx_p1_q);
        bb_i_p2_d = bb_i_p1_q;
        bb_q_p2_d = bb_q_p1_q;
        vld_p2_d  = vld_p1_q;
        // S3: full-precision products
        pi_p3_d   = OUT_W'(bb_i_p2_q) * OUT_W'(cos_p2_q);
        pq_p3_d   = OUT_W'(bb_q_p2_q) * OUT_W'(sin_p2_q);
        vld_p3_d  = vld_p2_q;
        // S4: combine; magnitude bound keeps this inside OUT_W bits
        rf_p4_d   = pi_p3_q - pq_p3_q;
        vld_p4_d  = vld_p3_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bb_i_p1_q <= '0;
            bb_q_p1_q <= '0;
            idx_p1_q  <= '0;
            vld_p1_q  <= 1'b0;
            cos_p2_q  <= '0;
            sin_p2_q  <= '0;
            bb_i_p2_q <= '0;
            bb_q_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            pi_p3_q   <= '0;
            pq_p3_q   <= '0;
            vld_p3_q  <= 1'b0;
            rf_p4_q   <= '0;
            vld_p4_q  <= 1'b0;
        end else if (clk_en) begin
            bb_i_p1_q <= bb_i_p1_d;
            bb_q_p1_q <= bb_q_p1_d;
            idx_p1_q  <= idx_p1_d;
            vld_p1_q  <= vld_p1_d;
            cos_p2_q  <= cos_p2_d;
            sin_p2_q  <= sin_p2_d;
            bb_i_p2_q <= bb_i_p2_d;
            bb_q_p2_q <= bb_q_p2_d;
            vld_p2_q  <= vld_p2_d;
            pi_p3_q   <= pi_p3_d;
            pq_p3_q   <= pq_p3_d;
            vld_p3_q  <= vld_p3_d;
            rf_p4_q   <= rf_p4_d;
            vld_p4_q  <= vld_p4_d;
        end
    end

    assign fcw_ready = fcw_ready_q;
    assign rf_out    = rf_p4_q;
    assign out_valid = vld_p4_q;

endmodule

// File: tb/tb_quadrature_upconverter.sv
// Directed bench for quadrature_upconverter: fixed carriers, extremes, word switching,
// clock-enable gating and reset behaviour against hand-derived LO values.
module tb_quadrature_upconverter;

    logic              clock = 1'b0;
    logic              reset, clk_en, phase_clear, fcw_valid;
    logic signed [4:0] bb_i, bb_q;
    logic [15:0]       fcw_in;
    logic              fcw_ready;
    logic signed [9:0] rf_out;
    logic              out_valid;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    quadrature_upconverter dut (
        .clock       (clock),
        .reset       (reset),
        .clk_en      (clk_en),
        .bb_i        (bb_i),
        .bb_q        (bb_q),
        .phase_clear (phase_clear),
        .fcw_in      (fcw_in),
        .fcw_valid   (fcw_valid),
        .fcw_ready   (fcw_ready),
        .rf_out      (rf_out),
        .out_valid   (out_valid)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int cos_q[4]  = '{15, 0, -15, 0};
    int msin_q[4] = '{0, -15, 0, 15};
    int ext_q[4]  = '{-240, -225, 240, 225};
    int t4_seq[8] = '{0, -15, 0, 15, 11, 0, -11, -15};
    int cos8[8]   = '{15, 11, 0, -11, -15, -11, 0, 11};
    int t6_seq[7] = '{30, 30, 30, 30, -30, 30, -30};
    logic [0:19] pat;
    int n;
    int exp_rf;

    initial begin
        reset = 1'b1; clk_en = 1'b1; phase_clear = 1'b0; fcw_valid = 1'b0;
        fcw_in = '0; bb_i = '0; bb_q = '0;
        tick(); tick();
        chk("rst_rf", rf_out, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", fcw_ready, 1);

        // Test 1: fcw 0, constant I/Q
        reset = 1'b0; bb_i = 5'sd3; bb_q = 5'sd7;
        tick(); tick(); tick();
        chk("t1_vld_early", out_valid, 0);
        tick();
        chk("t1_vld", out_valid, 1);
        chk("t1_rf", rf_out, 45);
        tick();
        chk("t1_rf_hold", rf_out, 45);

        // Load 0x4000 while active word is 0: applied on the next enabled cycle
        fcw_in = 16'h4000; fcw_valid = 1'b1;
        tick();
        fcw_valid = 1'b0;
        chk("t2_rdy_lo", fcw_ready, 0);
        tick();
        chk("t2_rdy_hi", fcw_ready, 1);

        // Test 2: quarter-turn carrier, I then Q
        bb_i = 5'sd1; bb_q = 5'sd0; phase_clear = 1'b1;
        tick(); phase_clear = 1'b0; tick(); tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_i", rf_out, cos_q[k % 4]);
        end
        bb_i = 5'sd0; bb_q = 5'sd1; phase_clear = 1'b1;
        tick(); phase_clear = 1'b0; tick(); tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_q", rf_out, msin_q[k % 4]);
        end

        // Test 3: input extremes
        bb_i = -5'sd16; bb_q = 5'sd15; phase_clear = 1'b1;
        tick(); phase_clear = 1'b0; tick(); tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_ext", rf_out, ext_q[k % 4]);
        end

        // Test 4: switch 0x4000 -> 0x2000, applied at the wrap from 0xC000
        bb_i = 5'sd1; bb_q = 5'sd0; phase_clear = 1'b1;
        tick();
        phase_clear = 1'b0; fcw_in = 16'h2000; fcw_valid = 1'b1;
        tick();
        fcw_valid = 1'b0;
        chk("t4_rdy_lo1", fcw_ready, 0);
        tick();
        chk("t4_rdy_lo2", fcw_ready, 0);
        tick();
        chk("t4_rdy_hi", fcw_ready, 1);
        chk("t4_rf0", rf_out, 15);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t4_seq", rf_out, t4_seq[k]);
        end

        // Test 5: clk_en gating; inputs and phase_clear while disabled must be ignored
        pat = 20'b1110_0110_1000_1101_0111;
        clk_en = 1'b1; phase_clear = 1'b1; bb_i = 5'sd1; bb_q = 5'sd0;
        tick();
        n = 1; exp_rf = 0;
        for (int i = 0; i < 20; i++) begin
            clk_en = pat[i];
            if (pat[i]) begin
                bb_i = 5'sd1; phase_clear = 1'b0;
            end else begin
                bb_i = -5'sd5; phase_clear = 1'b1;
            end
            tick();
            if (pat[i]) begin
                n++;
                if (n >= 4) begin
                    exp_rf = cos8[(n - 4) % 8];
                    chk("t5_en", rf_out, exp_rf);
                end
            end else begin
                chk("t5_hold", rf_out, exp_rf);
                chk("t5_vld_hold", out_valid, 1);
            end
        end
        clk_en = 1'b1; phase_clear = 1'b0;

        // Test 6: reset with a word pending and a full pipeline
        fcw_in = 16'h4000; fcw_valid = 1'b1;
        tick();
        fcw_valid = 1'b0;
        chk("t6_rdy_pend", fcw_ready, 0);
        reset = 1'b1; clk_en = 1'b0;
        tick();
        chk("t6_rst_rf", rf_out, 0);
        chk("t6_rst_vld", out_valid, 0);
        chk("t6_rst_rdy", fcw_ready, 1);
        reset = 1'b0; clk_en = 1'b1; bb_i = 5'sd2; bb_q = 5'sd3;
        tick(); tick(); tick();
        chk("t6_vld_early", out_valid, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_rf_const", rf_out, 30);
        end
        chk("t6_vld", out_valid, 1);

        // Word loaded while disabled with active word 0: applies on next enabled edge
        clk_en = 1'b0; fcw_in = 16'h8000; fcw_valid = 1'b1;
        tick();
        fcw_valid = 1'b0;
        chk("t5z_rdy_lo1", fcw_ready, 0);
        tick();
        chk("t5z_rdy_lo2", fcw_ready, 0);
        chk("t5z_hold", rf_out, 30);
        clk_en = 1'b1;
        tick();
        chk("t5z_rdy_hi", fcw_ready, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t5z_seq", rf_out, t6_seq[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
